// File: rtl/merge_pkg.sv
// merge_pkg: shared types and default parameters for the grant merge stage.
//   merge_state_t : sequencing states of the merge FSM
//   DEF_*         : default packet width, grant queue depth, counter width
package merge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // nothing in flight, waiting for a queued grant
        FETCH = 2'd1,   // granted source's ready is up, waiting for its packet
        SEND  = 2'd2    // packet held on the output port until accepted
    } merge_state_t;

    localparam int DEF_WIDTH  = 33;
    localparam int DEF_GDEPTH = 4;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/grant_fifo.sv
// grant_fifo: small synchronous FIFO holding arbiter grant decisions.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe and data (ignored while full)
//   pop, dout  : read strobe (ignored while empty) and head-of-queue data
//   full/empty : occupancy status
//   count      : current occupancy, one bit wider than the pointers
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module grant_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is not reset; an entry is only ever read after it has
    // been written, so clearing the array would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/grant_merge.sv
// grant_merge: consumer-side merge stage for the two-way request arbiter.
// Queues 1-bit grant decisions and forwards exactly one packet from the
// granted source per grant, in grant order, onto a single output port.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   g_valid/g_ready/g_sel      : grant input channel (g_sel = winning source)
//   dN_valid/dN_ready/dN_data  : source N packet channels (N = 0, 1)
//   o_valid/o_ready/o_data     : forwarded packet channel
//   o_src                      : source index of the packet on o_data
//   cnt0/cnt1                  : wrapping count of packets forwarded per source
//   gq_full/gq_empty           : grant queue status
module grant_merge
    import merge_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int GDEPTH = DEF_GDEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             g_valid,
    output logic             g_ready,
    input  logic             g_sel,
    input  logic             d0_valid,
    output logic             d0_ready,
    input  logic [WIDTH-1:0] d0_data,
    input  logic             d1_valid,
    output logic             d1_ready,
    input  logic [WIDTH-1:0] d1_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_src,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             gq_full,
    output logic             gq_empty
);

    merge_state_t               state;
    merge_state_t               state_n;
    logic                       cur_sel;
    logic                       cur_sel_n;
    logic                       gq_head;
    logic                       gq_pop;
    logic                       gq_has;
    logic [$clog2(GDEPTH):0]    gq_count;
    logic                       load;
    logic                       done;
    logic                       fetch_hit;

    // No push-through when full: acceptance depends on registered occupancy
    // only, so a pop in the same cycle does not reopen the queue.
    assign g_ready = !gq_full;

    grant_fifo #(
        .WIDTH (1),
        .DEPTH (GDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (g_valid),
        .din   (g_sel),
        .pop   (gq_pop),
        .dout  (gq_head),
        .full  (gq_full),
        .empty (gq_empty),
        .count (gq_count)
    );

    // The head entry is meaningful whenever occupancy is non-zero; entries
    // pushed this cycle are not visible until the next one.
    assign gq_has = (gq_count != '0);

    // The registered readies already encode which source is selected, so the
    // handshake itself tells FETCH that the packet has arrived.
    assign fetch_hit = (d0_valid && d0_ready) || (d1_valid && d1_ready);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        cur_sel_n = cur_sel;
        gq_pop    = 1'b0;
        load      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (gq_has) begin
                    gq_pop    = 1'b1;
                    cur_sel_n = gq_head;
                    state_n   = FETCH;
                end
            end
            FETCH: begin
                if (fetch_hit) begin
                    load    = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (o_ready) begin
                    done = 1'b1;
                    if (gq_has) begin
                        gq_pop    = 1'b1;
                        cur_sel_n = gq_head;
                        state_n   = FETCH;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Readies and o_valid are computed from the next state so they are true
    // flops aligned with the state they describe; no input reaches an output
    // combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_sel  <= 1'b0;
            d0_ready <= 1'b0;
            d1_ready <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_src    <= 1'b0;
            cnt0     <= '0;
            cnt1     <= '0;
        end else begin
            state    <= state_n;
            cur_sel  <= cur_sel_n;
            d0_ready <= (state_n == FETCH) && !cur_sel_n;
            d1_ready <= (state_n == FETCH) && cur_sel_n;
            o_valid  <= (state_n == SEND);
            if (load) begin
                o_data <= cur_sel ? d1_data : d0_data;
                o_src  <= cur_sel;
            end
            // Counters wrap naturally at 2^CNT_W.
            if (done) begin
                if (o_src) begin
                    cnt1 <= cnt1 + 1'b1;
                end else begin
                    cnt0 <= cnt0 + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_grant_merge.sv
// tb_grant_merge: self-checking bench for grant_merge. A cycle table covers
// single-grant latency and back-to-back forwarding; hand-written sequences
// cover reset, queue full and ordering, source stall, backpressure, counter
// wrap (second instance with 2-bit counters) and reset mid-flight.
module tb_grant_merge;
    import merge_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int CW = DEF_CNT_W;

    localparam logic [W-1:0] Z  = '0;
    localparam logic [W-1:0] D0 = 33'h0_DEAD_BEEF;
    localparam logic [W-1:0] D1 = 33'h1_2345_6789;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         g_valid, g_sel, d0_valid, d1_valid, o_ready;
    logic [W-1:0] d0_data, d1_data;

    logic          g_ready, d0_ready, d1_ready, o_valid, o_src, gq_full, gq_empty;
    logic [W-1:0]  o_data;
    logic [CW-1:0] cnt0, cnt1;

    logic          w_g_ready, w_d0_ready, w_d1_ready, w_o_valid, w_o_src;
    logic          w_gq_full, w_gq_empty;
    logic [W-1:0]  w_o_data;
    logic [1:0]    w_cnt0, w_cnt1;

    grant_merge dut (
        .clk(clk), .rst_n(rst_n),
        .g_valid(g_valid), .g_ready(g_ready), .g_sel(g_sel),
        .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_data(d0_data),
        .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_data(d1_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_src(o_src),
        .cnt0(cnt0), .cnt1(cnt1), .gq_full(gq_full), .gq_empty(gq_empty)
    );

    grant_merge #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .g_valid(g_valid), .g_ready(w_g_ready), .g_sel(g_sel),
        .d0_valid(d0_valid), .d0_ready(w_d0_ready), .d0_data(d0_data),
        .d1_valid(d1_valid), .d1_ready(w_d1_ready), .d1_data(d1_data),
        .o_valid(w_o_valid), .o_ready(o_ready), .o_data(w_o_data), .o_src(w_o_src),
        .cnt0(w_cnt0), .cnt1(w_cnt1), .gq_full(w_gq_full), .gq_empty(w_gq_empty)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        g_valid  = 1'b0;
        g_sel    = 1'b0;
        d0_valid = 1'b0;
        d1_valid = 1'b0;
        o_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Offers one grant, waits (bounded) for acceptance, then withdraws it.
    task automatic push_grant(input logic sel);
        int n;
        n       = 0;
        g_valid = 1'b1;
        g_sel   = sel;
        while (!g_ready && n < 40) begin
            tick();
            n++;
        end
        check("grant accept", g_ready, 1);
        tick();
        g_valid = 1'b0;
    endtask

    task automatic wait_ovalid(input int budget);
        int n;
        n = 0;
        while (!o_valid && n < budget) begin
            tick();
            n++;
        end
        check("o_valid arrival", o_valid, 1);
    endtask

    typedef struct {
        logic gv, gs, d0v, d1v, ordy;
        logic ov, osrc;
        logic [W-1:0] odata;
        logic d0r, d1r, gr, ge;
        int   c0, c1;
    } vec_t;

    vec_t tbl[11];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic         seq[5];
        logic [W-1:0] held_data;
        int           got;
        logic         seen;

        // Row i: inputs driven for one edge, outputs expected after that edge.
        //             gv    gs    d0v   d1v   ordy  | ov    osrc  odata d0r   d1r   gr    ge    c0 c1
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b1, 1'b1, 1'b1, 0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, D1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b1, 1'b1, 0, 1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b1, 1'b1, 0, 1};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b0, 0, 1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, D0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b1, 1'b1, 1'b1, 1, 1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, D1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b1, 1'b1, 1, 2};

        // ---- reset held with toggling inputs ----
        rst_n   = 1'b0;
        idle_inputs();
        d0_data = D0;
        d1_data = D1;
        for (int i = 0; i < 3; i++) begin
            g_valid  = 1'($urandom_range(0, 1));
            g_sel    = 1'($urandom_range(0, 1));
            d0_valid = 1'($urandom_range(0, 1));
            d1_valid = 1'($urandom_range(0, 1));
            o_ready  = 1'($urandom_range(0, 1));
            d0_data  = {1'($urandom_range(0, 1)), 32'($urandom)};
            d1_data  = {1'($urandom_range(0, 1)), 32'($urandom)};
            tick();
            check($sformatf("rst%0d o_valid", i), o_valid, 0);
            check($sformatf("rst%0d o_data", i), o_data, 0);
            check($sformatf("rst%0d o_src", i), o_src, 0);
            check($sformatf("rst%0d d0_ready", i), d0_ready, 0);
            check($sformatf("rst%0d d1_ready", i), d1_ready, 0);
            check($sformatf("rst%0d cnt0", i), cnt0, 0);
            check($sformatf("rst%0d cnt1", i), cnt1, 0);
            check($sformatf("rst%0d gq_empty", i), gq_empty, 1);
            check($sformatf("rst%0d gq_full", i), gq_full, 0);
        end
        idle_inputs();
        rst_n = 1'b1;
        #1;
        check("release g_ready", g_ready, 1);
        check("release gq_empty", gq_empty, 1);
        tick();
        check("idle o_valid", o_valid, 0);

        // ---- cycle table: single grant, then two back-to-back grants ----
        do_reset();
        d0_data = D0;
        d1_data = D1;
        for (int i = 0; i < 11; i++) begin
            g_valid  = tbl[i].gv;
            g_sel    = tbl[i].gs;
            d0_valid = tbl[i].d0v;
            d1_valid = tbl[i].d1v;
            o_ready  = tbl[i].ordy;
            tick();
            check($sformatf("row%0d o_valid", i), o_valid, tbl[i].ov);
            check($sformatf("row%0d d0_ready", i), d0_ready, tbl[i].d0r);
            check($sformatf("row%0d d1_ready", i), d1_ready, tbl[i].d1r);
            check($sformatf("row%0d g_ready", i), g_ready, tbl[i].gr);
            check($sformatf("row%0d gq_empty", i), gq_empty, tbl[i].ge);
            check($sformatf("row%0d cnt0", i), cnt0, tbl[i].c0);
            check($sformatf("row%0d cnt1", i), cnt1, tbl[i].c1);
            if (tbl[i].ov) begin
                check($sformatf("row%0d o_src", i), o_src, tbl[i].osrc);
                check($sformatf("row%0d o_data", i), o_data, tbl[i].odata);
            end
        end

        // ---- order and full: one grant in flight, four queued ----
        do_reset();
        d0_data  = 33'h0_0000_0A0A;
        d1_data  = 33'h1_0000_0B0B;
        d0_valid = 1'b1;
        d1_valid = 1'b1;
        seq      = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            push_grant(seq[i]);
        end
        g_valid = 1'b1;
        g_sel   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("full%0d g_ready", i), g_ready, 0);
            check($sformatf("full%0d gq_full", i), gq_full, 1);
            tick();
        end
        g_valid = 1'b0;
        o_ready = 1'b1;
        got     = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            if (o_valid) begin
                check($sformatf("order%0d o_src", got), o_src, seq[got]);
                check($sformatf("order%0d o_data", got), o_data,
                      seq[got] ? 33'h1_0000_0B0B : 33'h0_0000_0A0A);
                got++;
            end
            tick();
        end
        check("order packet count", got, 5);
        tick();
        check("order cnt0", cnt0, 2);
        check("order cnt1", cnt1, 3);
        check("order gq_empty", gq_empty, 1);
        check("order g_ready", g_ready, 1);

        // ---- source stall: granted source not valid, other source valid ----
        do_reset();
        d1_valid = 1'b1;
        d1_data  = 33'h1_FFFF_0000;
        push_grant(1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall%0d d0_ready", i), d0_ready, 1);
            check($sformatf("stall%0d d1_ready", i), d1_ready, 0);
            check($sformatf("stall%0d o_valid", i), o_valid, 0);
            tick();
        end
        d0_valid = 1'b1;
        d0_data  = 33'h0_0000_00AA;
        wait_ovalid(10);
        check("stall o_data", o_data, 33'h0_0000_00AA);
        check("stall o_src", o_src, 0);
        d0_valid = 1'b0;
        o_ready  = 1'b1;
        tick();
        o_ready = 1'b0;
        check("stall cnt0", cnt0, 1);
        check("stall cnt1", cnt1, 0);

        // ---- backpressure: held output stays stable, grants still queue ----
        held_data = 33'h1_5555_AAAA;
        d1_data   = held_data;
        push_grant(1'b1);
        wait_ovalid(10);
        d0_valid = 1'b1;
        d0_data  = 33'h0_0000_0077;
        for (int i = 0; i < 5; i++) begin
            g_valid = (i < 2);
            g_sel   = (i == 1);
            tick();
            check($sformatf("bp%0d o_valid", i), o_valid, 1);
            check($sformatf("bp%0d o_data", i), o_data, held_data);
            check($sformatf("bp%0d o_src", i), o_src, 1);
            check($sformatf("bp%0d d0_ready", i), d0_ready, 0);
            check($sformatf("bp%0d d1_ready", i), d1_ready, 0);
        end
        g_valid = 1'b0;
        check("bp occupancy", dut.u_fifo.count, 2);
        o_ready = 1'b1;
        tick();
        check("bp release cnt1", cnt1, 1);
        check("bp release d0_ready", d0_ready, 1);
        for (int i = 0; i < 10; i++) tick();
        check("bp drain cnt0", cnt0, 2);
        check("bp drain cnt1", cnt1, 2);
        check("bp drain gq_empty", gq_empty, 1);
        check("bp drain o_valid", o_valid, 0);

        // ---- counter wrap on the 2-bit instance ----
        do_reset();
        d0_valid = 1'b1;
        d0_data  = 33'h0_0000_0001;
        o_ready  = 1'b1;
        for (int i = 0; i < 5; i++) push_grant(1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("wrap w_cnt0", w_cnt0, 1);
        check("wrap w_cnt1", w_cnt1, 0);
        check("wrap cnt0", cnt0, 5);

        // ---- reset while in SEND with two grants queued ----
        o_ready  = 1'b0;
        d1_valid = 1'b1;
        push_grant(1'b1);
        push_grant(1'b0);
        push_grant(1'b1);
        wait_ovalid(10);
        check("midrst occupancy", dut.u_fifo.count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst o_valid", o_valid, 0);
        check("midrst gq_empty", gq_empty, 1);
        check("midrst cnt0", cnt0, 0);
        check("midrst w_cnt0", w_cnt0, 0);
        tick();
        tick();
        rst_n   = 1'b1;
        o_ready = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (o_valid) seen = 1'b1;
            tick();
        end
        check("post-reset no output", seen, 0);
        check("post-reset cnt0", cnt0, 0);
        check("post-reset cnt1", cnt1, 0);
        check("post-reset gq_empty", gq_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
